// File: rtl/v65C02_pkg.sv
// Shared v65C02 bus definitions: UART register offsets, STATUS bit positions and TX FSM states.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package v65C02_pkg;

    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIVLO  = 2'd2;
    localparam logic [1:0] UART_DIVHI  = 2'd3;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_port_if.sv
// CPU-side bus of the UART transmitter: block select, write strobe, offset, write data, read data.
interface uart_tx_port_if;
    logic       en_i;
    logic       we_i;
    logic [7:0] addr_i;
    logic [7:0] din_i;
    logic [7:0] dout_o;

    modport master (output en_i, we_i, addr_i, din_i, input dout_o);
    modport slave  (input en_i, we_i, addr_i, din_i, output dout_o);
endinterface

// File: rtl/uart_tx_port_txfifo.sv
// Single-clock transmit FIFO with show-ahead read data; a push while full is taken
// only when a pop happens on the same edge.
module TxFIFO #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full_o  = (r_count == FULL_CNT);
    assign empty_o = (r_count == '0);
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);
    assign dout_o  = r_mem[r_rd];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter at $9200-$92FF: register decode, bit timer and framing FSM.
// Define UART_TX_PARITY_EN for 8E1 framing; the default build is 8N1.
module uart_tx_port
    import v65C02_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic          clk_i,
    input  logic          rst_i,
    uart_tx_port_if.slave bus,
    output logic          tx_o
);
    logic           w_rd;
    logic           w_wr;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic           w_busy;
    logic           w_bit_end;
    logic [7:0]     w_fifo_dout;
    logic [7:0]     w_status;
    logic           w_unused_addr;

    logic [15:0]    r_div;
    logic           r_ovf;
    logic [7:0]     r_dout;
    uart_tx_state_t r_state;
    logic [15:0]    r_timer;
    logic [2:0]     r_bitcnt;
    logic [7:0]     r_shift;
    logic           r_tx;
`ifdef UART_TX_PARITY_EN
    logic           r_parity;
`endif

    assign w_unused_addr = &{1'b0, bus.addr_i[7:2]};

    assign w_rd      = bus.en_i && !bus.we_i;
    assign w_wr      = bus.en_i && bus.we_i;
    assign w_push    = w_wr && (bus.addr_i[1:0] == UART_DATA);
    assign w_busy    = (r_state != S_IDLE);
    assign w_bit_end = (r_timer == 16'd0);
    // Popping at the end of the stop bit chains frames without an idle gap.
    assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    always_comb begin
        w_status           = 8'h00;
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_BUSY]  = w_busy;
        w_status[ST_OVF]   = r_ovf;
    end

    TxFIFO #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .din_i   (bus.din_i),
        .pop_i   (w_pop),
        .dout_o  (w_fifo_dout),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div  <= DIV_RESET;
            r_ovf  <= 1'b0;
            r_dout <= 8'h00;
        end else begin
            if (w_wr && (bus.addr_i[1:0] == UART_DIVLO)) begin
                r_div[7:0] <= bus.din_i;
            end
            if (w_wr && (bus.addr_i[1:0] == UART_DIVHI)) begin
                r_div[15:8] <= bus.din_i;
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_rd && (bus.addr_i[1:0] == UART_STATUS)) begin
                r_ovf <= 1'b0;
            end
            if (w_rd) begin
                case (bus.addr_i[1:0])
                    UART_STATUS: r_dout <= w_status;
                    UART_DIVLO:  r_dout <= r_div[7:0];
                    UART_DIVHI:  r_dout <= r_div[15:8];
                    default:     r_dout <= 8'h00;
                endcase
            end
        end
    end

    // The line level is registered from the current state, so tx_o trails the FSM by one clock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_timer  <= 16'd0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift  <= w_fifo_dout;
                        r_timer  <= r_div;
                        r_state  <= S_START;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_fifo_dout;
`endif
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (w_bit_end) begin
                        r_timer  <= r_div;
                        r_bitcnt <= 3'd0;
                        r_state  <= S_DATA;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_bit_end) begin
                        r_timer <= r_div;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    r_tx <= r_parity;
                    if (w_bit_end) begin
                        r_timer <= r_div;
                        r_state <= S_STOP;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift  <= w_fifo_dout;
                            r_timer  <= r_div;
                            r_state  <= S_START;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_fifo_dout;
`endif
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dout_o = r_dout;
    assign tx_o       = r_tx;

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: a frame-level model (byte queue, bit list, per-bit clock budget)
// checked every cycle, plus literal expectations for reset, waveforms, STATUS and DIV behaviour.
module tb_uart_tx_port;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic hist [0:4095];

    uart_tx_port_if bus();

    uart_tx_port #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd433)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus),
        .tx_o  (tx)
    );

    always #10 clk = ~clk;

    // Model state: bytes waiting, the frame on the wire and how long its current bit still lasts.
    byte unsigned m_q[$];
    logic [15:0]  m_div  = 16'd433;
    logic         m_ovf  = 1'b0;
    logic [7:0]   m_dout = 8'h00;
    logic         m_line = 1'b1;
    logic         m_busy = 1'b0;
    logic         m_bits [0:10];
    int           m_idx  = 0;
    int           m_left = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic       rd, wr, full_pre, fin, popped;
        logic [1:0] a;
        byte unsigned b;
        if (rst) begin
            m_q.delete();
            m_div  = 16'd433;
            m_ovf  = 1'b0;
            m_dout = 8'h00;
            m_line = 1'b1;
            m_busy = 1'b0;
            m_idx  = 0;
            m_left = 0;
            return;
        end
        rd       = bus.en_i && !bus.we_i;
        wr       = bus.en_i && bus.we_i;
        a        = bus.addr_i[1:0];
        full_pre = (m_q.size() == DEPTH);
        if (rd) begin
            case (a)
                2'd0: m_dout = 8'h00;
                2'd1: m_dout = {4'b0000, m_ovf, m_busy, (m_q.size() == 0), full_pre};
                2'd2: m_dout = m_div[7:0];
                default: m_dout = m_div[15:8];
            endcase
        end
        m_line = m_busy ? m_bits[m_idx] : 1'b1;
        fin = 1'b0;
        if (m_busy) begin
            if (m_left == 1) begin
                if (m_idx == NB - 1) fin = 1'b1;
                else begin
                    m_idx++;
                    m_left = int'(m_div) + 1;
                end
            end else begin
                m_left--;
            end
        end
        popped = 1'b0;
        if (!m_busy || fin) begin
            if (m_q.size() > 0) begin
                b = m_q.pop_front();
                m_bits[0] = 1'b0;
                for (int k = 0; k < 8; k++) m_bits[k+1] = b[k];
                m_bits[9]    = ^b;
                m_bits[NB-1] = 1'b1;
                m_idx  = 0;
                m_left = int'(m_div) + 1;
                m_busy = 1'b1;
                popped = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end
        if (wr && a == 2'd0) begin
            if (full_pre && !popped) m_ovf = 1'b1;
            else m_q.push_back(bus.din_i);
        end
        if (rd && a == 2'd1) m_ovf = 1'b0;
        if (wr && a == 2'd2) m_div[7:0]  = bus.din_i;
        if (wr && a == 2'd3) m_div[15:8] = bus.din_i;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                hist[cyc % 4096] = tx;
                check("tx_vs_model", {15'd0, tx}, {15'd0, m_line});
                check("dout_vs_model", {8'd0, bus.dout_o}, {8'd0, m_dout});
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, output int edge_n);
        logic [7:0] ad;
        ad = 8'($urandom_range(0, 63));
        bus.addr_i = {ad[5:0], a};
        bus.din_i  = d;
        bus.we_i   = 1'b1;
        bus.en_i   = 1'b1;
        @(posedge clk);
        #1;
        edge_n   = cyc;
        bus.en_i = 1'b0;
        bus.we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] v);
        logic [7:0] ad;
        ad = 8'($urandom_range(0, 63));
        bus.addr_i = {ad[5:0], a};
        bus.we_i   = 1'b0;
        bus.en_i   = 1'b1;
        @(posedge clk);
        #1;
        bus.en_i = 1'b0;
        @(negedge clk);
        v = bus.dout_o;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_hist(input string name, input int c, input logic exp);
        check(name, {15'd0, hist[c % 4096]}, {15'd0, exp});
    endtask

    initial begin
        logic [7:0]  v;
        logic [10:0] pat;
        int          n, x;
        bus.en_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 8'h00; bus.din_i = 8'h00;
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", {15'd0, tx}, 16'd1);
        check("reset_dout", {8'd0, bus.dout_o}, 16'h00);
        bus_read(2'd1, v); check("reset_status", {8'd0, v}, 16'h02);
        bus_read(2'd2, v); check("reset_divlo", {8'd0, v}, 16'hB1);
        bus_read(2'd3, v); check("reset_divhi", {8'd0, v}, 16'h01);

        // DIV=3, byte $55: 10 bits of 4 clocks, start falls 2 clocks after the write edge
        bus_write(2'd2, 8'd3, x);
        bus_write(2'd3, 8'd0, x);
        bus_write(2'd0, 8'h55, n);
        wait_cycles(10);
        bus_read(2'd1, v); check("busy_status", {8'd0, v}, 16'h06);
        wait_until(n + 45);
        pat = {1'b0, 10'b1_01010101_0};
        check_hist("frame55_pre", n + 1, 1'b1);
        for (int j = 0; j < 10; j++)
            for (int r = 0; r < 4; r++) check_hist("frame55_bit", n + 2 + 4 * j + r, pat[j]);
        check_hist("frame55_post", n + 42, 1'b1);
        bus_read(2'd1, v); check("idle_status", {8'd0, v}, 16'h02);

        // Overflow: one byte in flight, then 17 writes fill 16 slots and drop the last
        bus_write(2'd0, 8'hA0, n);
        for (int i = 0; i < 17; i++) bus_write(2'd0, 8'(8'h10 + i), x);
        bus_read(2'd1, v); check("ovf_status", {8'd0, v}, 16'h0D);
        bus_read(2'd1, v); check("ovf_cleared", {8'd0, v}, 16'h05);
        // push into a full FIFO on the edge that pops the next byte
        wait_until(n + 40);
        bus_write(2'd0, 8'hEE, x);
        bus_read(2'd1, v); check("push_pop_full", {8'd0, v}, 16'h05);
        wait_cycles(18 * 40 + 20);
        bus_read(2'd1, v); check("drain_status", {8'd0, v}, 16'h02);

        // DIV changed mid start bit: start keeps 8 clocks, later bits take 2
        bus_write(2'd2, 8'd7, x);
        bus_write(2'd0, 8'h01, n);
        wait_until(n + 3);
        bus_write(2'd2, 8'd1, x);
        wait_cycles(40);
        for (int k = 2; k <= 9; k++) check_hist("div_start", n + k, 1'b0);
        check_hist("div_bit0a", n + 10, 1'b1);
        check_hist("div_bit0b", n + 11, 1'b1);
        check_hist("div_bit1a", n + 12, 1'b0);
        check_hist("div_bit1b", n + 13, 1'b0);

        // Reset during data bit 3 with four bytes queued
        bus_write(2'd2, 8'd3, x);
        bus_write(2'd0, 8'h11, n);
        for (int i = 0; i < 4; i++) bus_write(2'd0, 8'(8'h12 + i), x);
        wait_until(n + 19);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_hist("pre_reset_bit3", n + 19, 1'b0);
        check("reset_mid_tx", {15'd0, tx}, 16'd1);
        bus_read(2'd1, v); check("reset_mid_status", {8'd0, v}, 16'h02);
        x = cyc;
        wait_cycles(60);
        for (int k = 1; k <= 58; k++) check_hist("reset_idle", x + k, 1'b1);

        // DIV=0, byte $07: one clock per bit
        bus_write(2'd2, 8'd0, x);
        bus_write(2'd3, 8'd0, x);
        bus_write(2'd0, 8'h07, n);
        wait_cycles(20);
`ifdef UART_TX_PARITY_EN
        pat = 11'b1_1_00000111_0;
`else
        pat = {1'b0, 10'b1_00000111_0};
`endif
        check_hist("div0_pre", n + 1, 1'b1);
        for (int j = 0; j < NB; j++) check_hist("div0_bit", n + 2 + j, pat[j]);
        check_hist("div0_post", n + 2 + NB, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
